// File: rtl/dual_issue_queue_if.sv
// Issue-queue bus: fetch-side push handshake, downstream stall/flush,
// and the two issue slots with their enables and the pairing freeze flag.
// master = fetch/control side, slave = the queue itself.
interface dual_issue_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid0;
    logic            in_valid1;
    logic [XLEN-1:0] in_instr0;
    logic [XLEN-1:0] in_instr1;
    logic            in_ready;
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] instruction0;
    logic [XLEN-1:0] instruction1;
    logic            datapath_1_enable;
    logic            datapath_2_enable;
    logic            freeze2;

    modport master (
        output in_valid0, in_valid1, in_instr0, in_instr1, stall, flush,
        input  in_ready, instruction0, instruction1,
               datapath_1_enable, datapath_2_enable, freeze2
    );

    modport slave (
        input  in_valid0, in_valid1, in_instr0, in_instr1, stall, flush,
        output in_ready, instruction0, instruction1,
               datapath_1_enable, datapath_2_enable, freeze2
    );
endinterface

// File: rtl/dual_issue_queue.sv
// Dual-issue instruction queue: circular buffer fed two-wide from fetch,
// issuing one or two instructions per cycle after an RV32I pairing check
// (RAW on H0's rd, control-flow in H0, two memory ops sharing one port).
// Optional macro ISSUE_STATS_EN adds saturating dual/single/hazard counters.
module dual_issue_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic               clk,
    input  logic               rst,
    dual_issue_queue_if.slave  bus
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]        stat_dual,
    output logic [31:0]        stat_single,
    output logic [31:0]        stat_hazard
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  instr0_q, instr0_d;
    logic [XLEN-1:0]  instr1_q, instr1_d;
    logic             en1_q, en1_d;
    logic             en2_q, en2_d;
    logic             freeze2_q, freeze2_d;

    logic [XLEN-1:0]  h0, h1;
    logic             h0_writes_rd, h1_reads_rs1, h1_reads_rs2;
    logic             raw_hazard, ctrl_hazard, mem_hazard, hazard;
    logic [XLEN-1:0]  dec_instr0, dec_instr1;
    logic             dec_en1, dec_en2, dec_freeze2;
    logic [1:0]       dec_n;
    logic             in_ready;
    logic             push_ok;
    logic [CNT_W-1:0] n_push, n_pop;

    // Room for a full fetch pair, judged from the registered occupancy only
    assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

    assign bus.in_ready          = in_ready;
    assign bus.instruction0      = instr0_q;
    assign bus.instruction1      = instr1_q;
    assign bus.datapath_1_enable = en1_q;
    assign bus.datapath_2_enable = en2_q;
    assign bus.freeze2           = freeze2_q;

    // Pairing hazard check between the two oldest queue entries
    always_comb begin
        h0 = mem_q[rd_ptr_q];
        h1 = mem_q[rd_ptr_q + PTR_W'(1)];
        h0_writes_rd = (h0[11:7] != 5'd0) && (h0[6:0] != OP_STORE) && (h0[6:0] != OP_BRANCH);
        h1_reads_rs1 = (h1[6:0] != OP_LUI) && (h1[6:0] != OP_AUIPC) && (h1[6:0] != OP_JAL);
        h1_reads_rs2 = (h1[6:0] == OP_REG) || (h1[6:0] == OP_STORE) || (h1[6:0] == OP_BRANCH);
        raw_hazard   = h0_writes_rd &&
                       ((h1_reads_rs1 && (h1[19:15] == h0[11:7])) ||
                        (h1_reads_rs2 && (h1[24:20] == h0[11:7])));
        ctrl_hazard  = (h0[6:0] == OP_BRANCH) || (h0[6:0] == OP_JAL) || (h0[6:0] == OP_JALR);
        mem_hazard   = ((h0[6:0] == OP_LOAD) || (h0[6:0] == OP_STORE)) &&
                       ((h1[6:0] == OP_LOAD) || (h1[6:0] == OP_STORE));
        hazard       = raw_hazard || ctrl_hazard || mem_hazard;
    end

    // Issue decision from current occupancy; slot 1 shows NOP whenever idle
    always_comb begin
        dec_instr0  = NOP;
        dec_instr1  = NOP;
        dec_en1     = 1'b0;
        dec_en2     = 1'b0;
        dec_freeze2 = 1'b0;
        dec_n       = 2'd0;
        if (count_q == CNT_W'(1)) begin
            dec_instr0 = h0;
            dec_en1    = 1'b1;
            dec_n      = 2'd1;
        end else if (count_q >= CNT_W'(2)) begin
            dec_instr0 = h0;
            dec_en1    = 1'b1;
            if (hazard) begin
                dec_freeze2 = 1'b1;
                dec_n       = 2'd1;
            end else begin
                dec_instr1 = h1;
                dec_en2    = 1'b1;
                dec_n      = 2'd2;
            end
        end
    end

    // Next-state: flush beats stall and push; stall freezes issue and head
    always_comb begin
        push_ok   = in_ready && bus.in_valid0 && !bus.flush;
        n_push    = push_ok ? (bus.in_valid1 ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);
        n_pop     = '0;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
        instr0_d  = instr0_q;
        instr1_d  = instr1_q;
        en1_d     = en1_q;
        en2_d     = en2_q;
        freeze2_d = freeze2_q;
        if (bus.flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            instr0_d  = NOP;
            instr1_d  = NOP;
            en1_d     = 1'b0;
            en2_d     = 1'b0;
            freeze2_d = 1'b0;
        end else if (!bus.stall) begin
            n_pop     = CNT_W'(dec_n);
            rd_ptr_d  = rd_ptr_q + PTR_W'(dec_n);
            instr0_d  = dec_instr0;
            instr1_d  = dec_instr1;
            en1_d     = dec_en1;
            en2_d     = dec_en2;
            freeze2_d = dec_freeze2;
        end
        count_d = bus.flush ? '0 : (count_q + n_push - n_pop);
    end

    // Queue storage write; no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.in_instr0;
            if (bus.in_valid1) begin
                mem_q[wr_ptr_q + PTR_W'(1)] <= bus.in_instr1;
            end
        end
    end

    // Pointer, occupancy and issue register update
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            instr0_q  <= NOP;
            instr1_q  <= NOP;
            en1_q     <= 1'b0;
            en2_q     <= 1'b0;
            freeze2_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            instr0_q  <= instr0_d;
            instr1_q  <= instr1_d;
            en1_q     <= en1_d;
            en2_q     <= en2_d;
            freeze2_q <= freeze2_d;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual_q, stat_dual_d;
    logic [31:0] stat_single_q, stat_single_d;
    logic [31:0] stat_hazard_q, stat_hazard_d;
    logic        stat_tick;

    assign stat_dual   = stat_dual_q;
    assign stat_single = stat_single_q;
    assign stat_hazard = stat_hazard_q;

    // Saturating event counters for cycles where an issue decision is taken
    always_comb begin
        stat_tick     = !bus.stall && !bus.flush;
        stat_dual_d   = stat_dual_q;
        stat_single_d = stat_single_q;
        stat_hazard_d = stat_hazard_q;
        if (stat_tick && (dec_n == 2'd2) && (stat_dual_q != 32'hFFFF_FFFF))
            stat_dual_d = stat_dual_q + 32'd1;
        if (stat_tick && (dec_n == 2'd1) && (stat_single_q != 32'hFFFF_FFFF))
            stat_single_d = stat_single_q + 32'd1;
        if (stat_tick && dec_freeze2 && (stat_hazard_q != 32'hFFFF_FFFF))
            stat_hazard_d = stat_hazard_q + 32'd1;
    end

    // Counters clear on reset only, never on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_dual_q   <= '0;
            stat_single_q <= '0;
            stat_hazard_q <= '0;
        end else begin
            stat_dual_q   <= stat_dual_d;
            stat_single_q <= stat_single_d;
            stat_hazard_q <= stat_hazard_d;
        end
    end
`endif
endmodule

// File: tb/tb_dual_issue_queue.sv
// Scoreboard bench for dual_issue_queue: a driver applies directed then
// random cycles and pushes the expected post-edge outputs computed by an
// instruction-list reference model; a negedge monitor pops and compares.
module tb_dual_issue_queue;
    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_REG = 7'b0110011, OP_IMM = 7'b0010011;

    logic clk = 1'b0;
    logic rst;
    dual_issue_queue_if #(.XLEN(32)) bus();
`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual, stat_single, stat_hazard;
`endif

    dual_issue_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ISSUE_STATS_EN
        ,
        .stat_dual   (stat_dual),
        .stat_single (stat_single),
        .stat_hazard (stat_hazard)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, en1, en2, frz;
        logic [31:0] i0, i1, sd, ss, sh;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_q[$];
    exp_t        m;
    int          vectors = 0;
    int          miscompares = 0;

    // Pairing rule straight from the ISA field definitions
    function automatic bit pair_blocked(logic [31:0] a, logic [31:0] b);
        logic [6:0] oa = a[6:0];
        logic [6:0] ob = b[6:0];
        bit writes = (a[11:7] != 5'd0) && !(oa inside {OP_STORE, OP_BRANCH});
        bit r1 = !(ob inside {OP_LUI, OP_AUIPC, OP_JAL});
        bit r2 = ob inside {OP_REG, OP_STORE, OP_BRANCH};
        bit raw = writes && ((r1 && b[19:15] == a[11:7]) || (r2 && b[24:20] == a[11:7]));
        bit ctl = oa inside {OP_BRANCH, OP_JAL, OP_JALR};
        bit mem = (oa inside {OP_LOAD, OP_STORE}) && (ob inside {OP_LOAD, OP_STORE});
        return raw || ctl || mem;
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One clock: drive inputs, advance the model to the next edge, queue expectation
    task automatic step(input bit r, input bit v0, input bit v1,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit st, input bit fl);
        bit ready;
        rst = r;
        bus.in_valid0 = v0;
        bus.in_valid1 = v1;
        bus.in_instr0 = a;
        bus.in_instr1 = b;
        bus.stall = st;
        bus.flush = fl;
        if (r) begin
            model_q.delete();
            m.en1 = 0; m.en2 = 0; m.frz = 0; m.i0 = NOP; m.i1 = NOP;
            m.sd = 0; m.ss = 0; m.sh = 0;
        end else if (fl) begin
            model_q.delete();
            m.en1 = 0; m.en2 = 0; m.frz = 0; m.i0 = NOP; m.i1 = NOP;
        end else begin
            ready = (DEPTH - model_q.size()) >= 2;
            if (!st) begin
                m.en1 = 0; m.en2 = 0; m.frz = 0; m.i0 = NOP; m.i1 = NOP;
                if (model_q.size() == 1 ||
                    (model_q.size() >= 2 && pair_blocked(model_q[0], model_q[1]))) begin
                    m.en1 = 1;
                    m.frz = (model_q.size() >= 2);
                    m.i0 = model_q.pop_front();
                    m.ss = sat_inc(m.ss);
                    if (m.frz) m.sh = sat_inc(m.sh);
                end else if (model_q.size() >= 2) begin
                    m.en1 = 1; m.en2 = 1;
                    m.i0 = model_q.pop_front();
                    m.i1 = model_q.pop_front();
                    m.sd = sat_inc(m.sd);
                end
            end
            if (ready && v0) begin
                model_q.push_back(a);
                if (v1) model_q.push_back(b);
            end
        end
        m.rdy = (DEPTH - model_q.size()) >= 2;
        exp_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    function automatic logic [31:0] addi(int rd, int imm);
        logic [31:0] w;
        w = {12'(imm), 5'd0, 3'd0, 5'(rd), OP_IMM};
        return w;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [9] = '{OP_IMM, OP_REG, OP_LOAD, OP_STORE, OP_BRANCH,
                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 8)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %h expected %h", name, vectors, act, want);
        end
    endtask

    // Monitor: outputs are registered, so every cycle presents one vector
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("in_ready", 32'(bus.in_ready), 32'(e.rdy));
                chk("en1", 32'(bus.datapath_1_enable), 32'(e.en1));
                chk("en2", 32'(bus.datapath_2_enable), 32'(e.en2));
                chk("freeze2", 32'(bus.freeze2), 32'(e.frz));
                chk("instruction0", bus.instruction0, e.i0);
                chk("instruction1", bus.instruction1, e.i1);
`ifdef ISSUE_STATS_EN
                chk("stat_dual", stat_dual, e.sd);
                chk("stat_single", stat_single, e.ss);
                chk("stat_hazard", stat_hazard, e.sh);
`endif
            end
        end
    end

    initial begin
        bit r, v0, v1, st, fl;
        int waited;
        // reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h00500093, 32'h00700113, 0, 0);
        // independent pair dual-issues
        step(0, 1, 1, 32'h00500093, 32'h00700113, 0, 0);
        idle(3);
        // RAW pair: single issue with freeze2, then dependent op
        step(0, 1, 1, 32'h00500093, 32'h00108113, 0, 0);
        idle(3);
        // two loads, then branch leading a pair
        step(0, 1, 1, 32'h00002283, 32'h00402303, 0, 0);
        idle(3);
        step(0, 1, 1, 32'h00000463, 32'h00500093, 0, 0);
        idle(3);
        // fill under stall; fifth pair must be ignored; then drain
        for (int k = 0; k < 5; k++) step(0, 1, 1, addi(2 * k + 1, k), addi(2 * k + 2, k), 1, 0);
        idle(6);
        // flush with a partially full queue and a push in the same cycle
        for (int k = 0; k < 3; k++) step(0, 1, 1, addi(k + 1, 7), addi(k + 9, 7), 1, 0);
        step(0, 1, 1, addi(20, 1), addi(21, 1), 0, 1);
        idle(3);
        // single-slot push
        step(0, 1, 0, 32'h00500093, 32'hDEADBEEF, 0, 0);
        idle(2);
        // random traffic wrapping the pointers many times
        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 4) == 0);
            v0 = ($urandom_range(0, 9) < 7);
            v1 = v0 && ($urandom_range(0, 1) == 1);
            step(r, v0, v1, rnd_instr(), rnd_instr(), st, fl);
        end
        idle(2);
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
